// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, lock-holding arbiter sharing one uart_tx between byte-stream requesters
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int PAYLOAD_BITS = 8,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ-1:0]              req_last,
    input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [$clog2(NUM_REQ)-1:0]      grant_id,
    output logic                            locked,
    output logic                            uart_tx_en,
    output logic [PAYLOAD_BITS-1:0]         uart_tx_data,
    input  logic                            uart_tx_busy
);
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(LOCK_TIMEOUT);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_START, WAIT_DONE, HOLD} state_t;
    state_t state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d, grant_q, grant_d, pick, idx;
    logic [PAYLOAD_BITS-1:0] data_q, data_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic locked_q, locked_d, last_q, last_d, found, accept;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            ptr_q    <= IW'(NUM_REQ - 1);
            grant_q  <= '0;
            locked_q <= 1'b0;
            data_q   <= '0;
            last_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            locked_q <= locked_d;
            data_q   <= data_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
        end
    end

    // Round-robin search: the first valid requester after the pointer wins
    always_comb begin
        pick  = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = IW'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Next state: arbitration, frame sequencing against busy, lock hold and timeout
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        locked_d = locked_q;
        data_d   = data_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        case (state_q)
            IDLE: if (!uart_tx_busy && found) begin
                accept   = 1'b1;
                grant_d  = pick;
                locked_d = 1'b1;
                state_d  = SEND;
            end
            SEND: state_d = WAIT_START;
            WAIT_START: if (uart_tx_busy) state_d = WAIT_DONE;
            WAIT_DONE: if (!uart_tx_busy) begin
                if (last_q) begin
                    state_d  = IDLE;
                    locked_d = 1'b0;
                    ptr_d    = grant_q;
                end else begin
                    state_d = HOLD;
                    cnt_d   = '0;
                end
            end
            HOLD: if (cnt_q == CW'(LOCK_TIMEOUT - 2)) begin
                state_d  = IDLE;
                locked_d = 1'b0;
                ptr_d    = grant_q;
            end else if (req_valid[grant_q]) begin
                accept  = 1'b1;
                state_d = SEND;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            data_d = req_data[int'(grant_d)*PAYLOAD_BITS +: PAYLOAD_BITS];
            last_d = req_last[grant_d];
        end
    end

    // Outputs: one-hot accept strobe, send strobe in SEND, registered owner/lock/data
    always_comb begin
        req_ready    = (accept && !reset) ? (NUM_REQ'(1) << grant_d) : '0;
        uart_tx_en   = state_q == SEND;
        grant_id     = grant_q;
        locked       = locked_q;
        uart_tx_data = data_q;
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
    localparam int LT = 16;
    logic clk = 1'b0, reset = 1'b1;
    logic [3:0] req_valid = '0, req_last = '0, req_ready;
    logic [31:0] req_data = '0;
    logic [1:0] grant_id;
    logic locked, uart_tx_en, uart_tx_busy = 1'b0;
    logic [7:0] uart_tx_data;
    int errors = 0, checks = 0;

    uart_tx_arbiter #(.NUM_REQ(4), .PAYLOAD_BITS(8), .LOCK_TIMEOUT(LT)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_last(req_last),
        .req_data(req_data), .req_ready(req_ready), .grant_id(grant_id),
        .locked(locked), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Waits (bounded) for an accept, then plays a uart_tx frame of flen busy cycles
    task automatic xfer(input bit drop, input int flen, output logic [3:0] rdy,
                        output logic en1, output logic [7:0] d, output int spur, output bit ok);
        ok = 0; rdy = '0; en1 = 0; d = '0; spur = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req_ready != '0) begin
                ok = 1;
                rdy = req_ready;
                break;
            end
            step();
        end
        if (!ok) return;
        step();
        if (drop) req_valid = req_valid & ~rdy;
        #1;
        en1 = uart_tx_en;
        d = uart_tx_data;
        if (req_ready != '0) spur++;
        step();
        uart_tx_busy = 1;
        for (int i = 0; i < flen; i++) begin
            #1;
            if (req_ready != '0 || uart_tx_en) spur++;
            step();
        end
        uart_tx_busy = 0;
    endtask

    task automatic test_reset();
        reset = 1; req_valid = 4'b0001; uart_tx_busy = 0;
        repeat (3) step();
        #1;
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", req_ready); end
        checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL reset_en got %b want 0", uart_tx_en); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL reset_locked got %b want 0", locked); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", uart_tx_data); end
        reset = 0; req_valid = '0;
        step();
    endtask

    task automatic test_single_word();
        req_data = 32'h0000_0041; req_last = 4'b0001; req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", req_ready); end
        checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_early got %b want 0", uart_tx_en); end
        step();
        req_valid = '0;
        #1;
        checks++; if (uart_tx_en !== 1'b1) begin errors++; $display("FAIL single_en got %b want 1", uart_tx_en); end
        checks++; if (uart_tx_data !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", uart_tx_data); end
        checks++; if (locked !== 1'b1 || grant_id !== 2'd0) begin errors++; $display("FAIL single_lock got locked=%b grant=%0d want 1/0", locked, grant_id); end
        step();
        uart_tx_busy = 1;
        #1;
        checks++; if (uart_tx_en !== 1'b0) begin errors++; $display("FAIL single_en_width got %b want 0", uart_tx_en); end
        repeat (4) step();
        uart_tx_busy = 0;
        #1;
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked_busy got %b want 1", locked); end
        step();
        #1;
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL single_unlock got %b want 0", locked); end
    endtask

    task automatic test_round_robin();
        logic [3:0] rdy;
        logic en1;
        logic [7:0] d;
        int spur;
        bit ok;
        reset = 1; step(); reset = 0;
        req_data = 32'hA3A2_A1A0; req_last = 4'b1111; req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            logic [3:0] er;
            logic [7:0] ed;
            er = 4'b0001 << (k % 4);
            ed = 8'hA0 + 8'(k % 4);
            xfer(0, 3, rdy, en1, d, spur, ok);
            checks++; if (!ok) begin errors++; $display("FAIL rr_timeout k=%0d got no ready want ready", k); end
            checks++; if (rdy !== er) begin errors++; $display("FAIL rr_ready k=%0d got %b want %b", k, rdy, er); end
            checks++; if (grant_id !== 2'(k % 4)) begin errors++; $display("FAIL rr_grant k=%0d got %0d want %0d", k, grant_id, k % 4); end
            checks++; if (en1 !== 1'b1 || d !== ed) begin errors++; $display("FAIL rr_send k=%0d got en=%b data=%h want 1/%h", k, en1, d, ed); end
            checks++; if (spur !== 0) begin errors++; $display("FAIL rr_spurious k=%0d got %0d want 0", k, spur); end
        end
        req_valid = '0;
    endtask

    task automatic test_lock_hold();
        logic [3:0] rdy;
        logic en1;
        logic [7:0] d;
        int spur;
        bit ok;
        logic [3:0] er [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001};
        logic [7:0] ed [5] = '{8'h20, 8'h21, 8'h22, 8'h33, 8'h30};
        req_data = 32'h3320_3130; req_last = 4'b1011; req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin req_valid = 4'b1111; req_data[23:16] = 8'h21; end
            if (k == 2) begin req_last[2] = 1'b1; req_data[23:16] = 8'h22; end
            xfer(k == 2, 3, rdy, en1, d, spur, ok);
            checks++; if (!ok || rdy !== er[k]) begin errors++; $display("FAIL lock_ready k=%0d got %b want %b", k, rdy, er[k]); end
            checks++; if (d !== ed[k] || spur !== 0) begin errors++; $display("FAIL lock_data k=%0d got %h spur=%0d want %h spur=0", k, d, spur, ed[k]); end
        end
        req_valid = '0;
    endtask

    task automatic test_timeout();
        logic [3:0] rdy;
        logic en1;
        logic [7:0] d;
        int spur, n;
        bit ok;
        req_data = 32'h7700_5500; req_last = 4'b0000; req_valid = 4'b0010;
        xfer(1, 3, rdy, en1, d, spur, ok);
        checks++; if (!ok || rdy !== 4'b0010 || d !== 8'h55) begin errors++; $display("FAIL to_first got %b/%h want 0010/55", rdy, d); end
        req_valid = 4'b1000; req_last = 4'b1000;
        n = 0; spur = 0;
        #1;
        while (locked === 1'b1 && n < 100) begin
            if (req_ready != '0) spur++;
            step();
            #1;
            n++;
        end
        checks++; if (n !== LT) begin errors++; $display("FAIL to_cycles got %0d want %0d", n, LT); end
        checks++; if (spur !== 0) begin errors++; $display("FAIL to_hold_ready got %0d want 0", spur); end
        xfer(1, 3, rdy, en1, d, spur, ok);
        checks++; if (!ok || rdy !== 4'b1000 || d !== 8'h77) begin errors++; $display("FAIL to_next got %b/%h want 1000/77", rdy, d); end
        req_valid = '0;
    endtask

    task automatic test_timeout_race();
        logic [3:0] rdy;
        logic en1;
        logic [7:0] d;
        int spur;
        bit ok;
        req_data = 32'h00C2_00C0; req_last = 4'b0000; req_valid = 4'b0001;
        xfer(1, 3, rdy, en1, d, spur, ok);
        checks++; if (!ok || rdy !== 4'b0001) begin errors++; $display("FAIL race_first got %b want 0001", rdy); end
        req_valid = '0;
        repeat (LT - 1) step();
        req_valid = 4'b0101; req_last = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0000 || locked !== 1'b1) begin errors++; $display("FAIL race_expiry got ready=%b locked=%b want 0000/1", req_ready, locked); end
        step();
        #1;
        checks++; if (req_ready !== 4'b0100 || locked !== 1'b0) begin errors++; $display("FAIL race_rearb got ready=%b locked=%b want 0100/0", req_ready, locked); end
        xfer(1, 3, rdy, en1, d, spur, ok);
        checks++; if (!ok || rdy !== 4'b0100 || d !== 8'hC2) begin errors++; $display("FAIL race_send got %b/%h want 0100/c2", rdy, d); end
        req_valid = '0;
    endtask

    task automatic test_busy_guard();
        int nr, ne;
        logic [3:0] r;
        nr = 0; ne = 0;
        uart_tx_busy = 1; req_valid = 4'b0001; req_last = 4'b0001;
        for (int i = 0; i < 500; i++) begin
            #1;
            if (req_ready != '0) nr++;
            if (uart_tx_en) ne++;
            step();
        end
        checks++; if (nr !== 0 || ne !== 0) begin errors++; $display("FAIL guard_busy got ready=%0d en=%0d want 0/0", nr, ne); end
        uart_tx_busy = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            r = req_ready;
            if (r != '0) nr++;
            if (uart_tx_en) ne++;
            step();
            if (r != '0) req_valid = '0;
        end
        checks++; if (nr !== 1 || ne !== 1) begin errors++; $display("FAIL guard_release got ready=%0d en=%0d want 1/1", nr, ne); end
        req_valid = '0;
    endtask

    task automatic test_reset_midframe();
        int nr;
        reset = 1; uart_tx_busy = 0; req_valid = '0;
        step();
        reset = 0;
        req_data = 32'h005A_0000; req_last = 4'b0000; req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_accept got %b want 0100", req_ready); end
        step();
        req_valid = '0;
        step();
        uart_tx_busy = 1;
        step();
        #1;
        checks++; if (locked !== 1'b1 || grant_id !== 2'd2 || uart_tx_data !== 8'h5A) begin errors++; $display("FAIL mid_pre got locked=%b grant=%0d data=%h want 1/2/5a", locked, grant_id, uart_tx_data); end
        reset = 1; req_valid = 4'b0100;
        step();
        reset = 0;
        #1;
        checks++; if ({req_ready, uart_tx_en, locked, grant_id, uart_tx_data} !== 16'h0) begin errors++; $display("FAIL mid_reset got ready=%b en=%b locked=%b grant=%0d data=%h want all 0", req_ready, uart_tx_en, locked, grant_id, uart_tx_data); end
        nr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            #1;
            if (req_ready != '0) nr++;
        end
        checks++; if (nr !== 0) begin errors++; $display("FAIL mid_busy_ready got %0d want 0", nr); end
        step();
        uart_tx_busy = 0;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_release got %b want 0100", req_ready); end
        step();
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_round_robin();
        test_lock_hold();
        test_timeout();
        test_timeout_race();
        test_busy_guard();
        test_reset_midframe();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no finish want finish before 1ms");
        $fatal(1);
    end
endmodule
